// File: rtl/pxl_readout_pkg.sv
// pxl_readout_pkg: shared widths, depths and entry layout for the pixel readout buffer
package pxl_readout_pkg;

    localparam int PXL_DW         = 16;
    localparam int PXL_FIFO_DEPTH = 8;
    localparam int DROP_CNT_W     = 8;

    typedef struct packed {
        logic              last;
        logic [PXL_DW-1:0] data;
    } pxl_entry_t;

endpackage

// File: rtl/pxl_sync_fifo.sv
// pxl_sync_fifo: show-ahead synchronous FIFO with wrapping pointers and occupancy count
module pxl_sync_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign valid = level != '0;
    assign full  = level == (AW+1)'(DEPTH);
    assign rd    = pop && valid;
    assign wr    = push && (!full || rd);
    assign rdata = valid ? mem[rptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two; level tracks net push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end

    // Storage is never reset; the pointers alone decide what is live
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/pxl_readout_buf.sv
// pxl_readout_buf: captures pixel FSM results on done edges into a FIFO with overflow tracking
module pxl_readout_buf
    import pxl_readout_pkg::*;
#(
    parameter int DW    = PXL_DW,
    parameter int DEPTH = PXL_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pxl_done_i,
    input  logic [DW-1:0]             pxl_data_i,
    input  logic                      kernel_done_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    input  logic                      clr_ovf
);

    logic          done_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          drop;
    logic [DW:0]   head;

    assign push = pxl_done_i && !done_q;
    assign pop  = out_valid && out_ready;
    assign drop = push && full && !pop;
    assign {out_last, out_data} = head;

    pxl_sync_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({kernel_done_i, pxl_data_i}),
        .rdata (head),
        .valid (out_valid),
        .full  (full),
        .level (level)
    );

    // Previous done level so a held-high flag pushes only once
    always_ff @(posedge clk) begin
        done_q <= rst ? 1'b0 : pxl_done_i;
    end

    // Sticky overflow and saturating drop count; a drop in the clear cycle counts as the first
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= clr_ovf ? DROP_CNT_W'(1) : (&drop_cnt ? drop_cnt : drop_cnt + DROP_CNT_W'(1));
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pxl_readout_buf.sv
// tb_pxl_readout_buf: directed stimulus with a queue-based reference model checked every cycle
module tb_pxl_readout_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic [DW-1:0] data = '0;
    logic          kd = 1'b0;
    logic          ready = 1'b0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [3:0]    level;
    logic          ovf;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW:0] m_q [$];
    logic        m_prev = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;
    logic        m_live = 1'b0;
    logic        m_push;
    logic        m_pop;
    logic        m_drop;

    pxl_readout_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .pxl_done_i    (done),
        .pxl_data_i    (data),
        .kernel_done_i (kd),
        .out_valid     (out_valid),
        .out_ready     (ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .level         (level),
        .ovf           (ovf),
        .drop_cnt      (drop_cnt),
        .clr_ovf       (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries plus overflow bookkeeping, updated on each edge
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_push = done && !m_prev;
            m_pop  = (m_q.size() != 0) && ready;
            m_drop = 1'b0;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back({kd, data});
                else m_drop = 1'b1;
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                m_cnt = clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            m_prev = done;
        end
        m_live = 1'b1;
    end

    // Compare DUT against the model on the falling edge of every cycle
    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_valid", int'(out_valid), int'(m_q.size() != 0));
            chk("cmp_level", int'(level), m_q.size());
            chk("cmp_ovf", int'(ovf), int'(m_ovf));
            chk("cmp_drop_cnt", int'(drop_cnt), m_cnt);
            if (m_q.size() != 0) begin
                chk("cmp_data", int'(out_data), int'(m_q[0][DW-1:0]));
                chk("cmp_last", int'(out_last), int'(m_q[0][DW]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d, input logic k);
        done = 1'b1;
        data = d;
        kd   = k;
        tick();
        done = 1'b0;
        kd   = 1'b0;
        tick();
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        ready = 1'b0;
        chk("drain_empty", int'(level), 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);

        done = 1'b1;
        data = 16'h1234;
        tick();
        chk("first_valid", int'(out_valid), 1);
        chk("first_data", int'(out_data), 'h1234);
        chk("first_last", int'(out_last), 0);
        chk("first_level", int'(level), 1);
        done = 1'b0;
        tick();
        drain();

        done = 1'b1;
        data = 16'h0042;
        for (int i = 0; i < 5; i++) tick();
        chk("held_level", int'(level), 1);
        chk("held_model", m_q.size(), 1);
        done = 1'b0;
        tick();
        drain();

        for (int i = 0; i < 10; i++) push_one(16'h0100 + 16'(i), 1'b0);
        chk("fill_level", int'(level), 8);
        chk("fill_ovf", int'(ovf), 1);
        chk("fill_drop_cnt", int'(drop_cnt), 2);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", int'(out_data), 'h100 + i);
            tick();
        end
        ready = 1'b0;
        chk("drained_valid", int'(out_valid), 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_drop_cnt", int'(drop_cnt), 0);

        for (int i = 0; i < 8; i++) push_one(16'h0200 + 16'(i), 1'b0);
        ready = 1'b1;
        done  = 1'b1;
        data  = 16'h02AA;
        tick();
        ready = 1'b0;
        done  = 1'b0;
        chk("full_pp_level", int'(level), 8);
        chk("full_pp_ovf", int'(ovf), 0);
        tick();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("full_pp_order", int'(out_data), i == 7 ? 'h2AA : 'h201 + i);
            tick();
        end
        ready = 1'b0;

        for (int i = 0; i < 8; i++) push_one(16'h0300 + 16'(i), 1'b0);
        for (int i = 0; i < 300; i++) push_one(16'hDEAD, 1'b0);
        chk("sat_drop_cnt", int'(drop_cnt), 255);
        chk("sat_ovf", int'(ovf), 1);
        clr  = 1'b1;
        done = 1'b1;
        tick();
        clr  = 1'b0;
        done = 1'b0;
        chk("clr_drop_ovf", int'(ovf), 1);
        chk("clr_drop_cnt", int'(drop_cnt), 1);
        tick();
        drain();

        push_one(16'h00FF, 1'b1);
        chk("last_data", int'(out_data), 'h00FF);
        chk("last_flag", int'(out_last), 1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_stable", int'({out_last, out_data}), 'h100FF);
        end
        drain();

        for (int i = 0; i < 5; i++) push_one(16'h0400 + 16'(i), 1'b0);
        chk("pre_rst_level", int'(level), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", int'(out_valid), 0);
        end
        ready = 1'b0;

        done = 1'b1;
        data = 16'h0777;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_held_level", int'(level), 1);
        chk("rst_held_data", int'(out_data), 'h0777);
        tick();
        tick();
        chk("rst_held_once", int'(level), 1);
        done = 1'b0;
        tick();
        drain();

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
